// File: rtl/rc4_job_scheduler.sv
// Round-robin job scheduler sharing one RC4 keystream core among NUM_REQ requesters.
// Optional watchdog in RUN is enabled by defining RC4_SCHED_TIMEOUT_EN.
module rc4_job_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int NUMS_OF_BYTES  = 4,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUMS_OF_BYTES*8-1:0] req_key,
  input  logic [NUM_REQ*8-1:0]            req_key_len,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id,
  output logic [NUMS_OF_BYTES*8-1:0]      resp_ckey,
  output logic                            resp_err,
  output logic                            core_rst_n,
  output logic                            core_start,
  output logic [NUMS_OF_BYTES*8-1:0]      core_key,
  output logic [7:0]                      core_key_length,
  input  logic [NUMS_OF_BYTES*8-1:0]      core_ckey,
  input  logic                            core_done
);

  localparam int KW  = NUMS_OF_BYTES * 8;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_resp_valid;
  logic [IDW-1:0]     r_resp_id;
  logic [KW-1:0]      r_resp_ckey;
  logic               r_resp_err;
  logic               r_core_rst_n;
  logic               r_core_start;
  logic [KW-1:0]      r_core_key;
  logic [7:0]         r_core_len;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_bad_len;

`ifdef RC4_SCHED_TIMEOUT_EN
  logic [15:0]        r_wdog;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
    w_onehot[w_win] = 1'b1;
  end

  assign w_bad_len = (r_core_len == 8'd0) || (r_core_len > 8'(NUMS_OF_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_ckey  <= '0;
      r_resp_err   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_core_start <= 1'b0;
      r_core_key   <= '0;
      r_core_len   <= '0;
`ifdef RC4_SCHED_TIMEOUT_EN
      r_wdog       <= '0;
`endif
    end else begin
      r_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id       <= w_win;
            r_core_key <= req_key[int'(w_win)*KW +: KW];
            r_core_len <= req_key_len[int'(w_win)*8 +: 8];
            r_grant    <= w_onehot;
            r_busy     <= 1'b1;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_rr_ptr <= (int'(r_id) == NUM_REQ - 1) ? '0 : r_id + 1'b1;
          if (w_bad_len) begin
            r_resp_id    <= r_id;
            r_resp_err   <= 1'b1;
            r_resp_ckey  <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt   <= CW'(CLEAR_CYCLES - 1);
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == '0) begin
            r_core_rst_n <= 1'b1;
            r_core_start <= 1'b1;
`ifdef RC4_SCHED_TIMEOUT_EN
            r_wdog       <= '0;
`endif
            r_state      <= S_RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (core_done) begin
            r_resp_ckey  <= core_ckey;
            r_resp_err   <= 1'b0;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_core_start <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_state      <= S_RESP;
          end
`ifdef RC4_SCHED_TIMEOUT_EN
          else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
            r_resp_ckey  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_core_start <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant           = r_grant;
  assign busy            = r_busy;
  assign resp_valid      = r_resp_valid;
  assign resp_id         = r_resp_id;
  assign resp_ckey       = r_resp_ckey;
  assign resp_err        = r_resp_err;
  assign core_rst_n      = r_core_rst_n;
  assign core_start      = r_core_start;
  assign core_key        = r_core_key;
  assign core_key_length = r_core_len;

endmodule

// File: tb/tb_rc4_job_scheduler.sv
// Table-driven bench for rc4_job_scheduler with a behavioural RC4 core model.
module tb_rc4_job_scheduler;

  localparam int NR = 2;
  localparam int NB = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*NB*8-1:0] req_key = '0;
  logic [NR*8-1:0]    req_key_len = '0;
  logic [NR-1:0] grant;
  logic          busy;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_id;
  logic [31:0]   resp_ckey;
  logic          resp_err;
  logic          core_rst_n;
  logic          core_start;
  logic [31:0]   core_key;
  logic [7:0]    core_key_length;
  logic [31:0]   core_ckey = '0;
  logic          core_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_grant = 0;
  int n_start = 0;
  int core_lat = 30;
  logic hang_core = 1'b0;
  int run_cnt = 0;

  rc4_job_scheduler #(.NUM_REQ(NR), .NUMS_OF_BYTES(NB), .CLEAR_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_key(req_key), .req_key_len(req_key_len),
    .grant(grant), .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_ckey(resp_ckey), .resp_err(resp_err),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_key(core_key),
    .core_key_length(core_key_length), .core_ckey(core_ckey), .core_done(core_done)
  );

  always #5 clk = ~clk;

  // Reference RC4: KSA + first four PRGA bytes, byte n at [n*8 +: 8].
  function automatic logic [31:0] rc4(input logic [31:0] key, input logic [7:0] len);
    logic [7:0] s [256];
    logic [7:0] kb [4];
    logic [7:0] t;
    logic [31:0] out;
    int i, j;
    out = '0;
    if (len == 8'd0 || len > 8'd4) return out;
    for (int k = 0; k < 4; k++) kb[k] = key[k*8 +: 8];
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + int'(s[k]) + int'(kb[k % int'(len)])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < 4; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      out[n*8 +: 8] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
    return out;
  endfunction

  // Core model: synchronous active-low reset, done after core_lat started cycles.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_done <= 1'b0;
      run_cnt   <= 0;
    end else if (core_start && !core_done && !hang_core) begin
      if (run_cnt == core_lat - 1) begin
        core_done <= 1'b1;
        core_ckey <= rc4(core_key, core_key_length);
      end
      run_cnt <= run_cnt + 1;
    end
  end

  typedef struct {
    logic [1:0]  req;
    logic [31:0] key0;
    logic [7:0]  len0;
    logic [31:0] key1;
    logic [7:0]  len1;
    logic [1:0]  exp_grant;
    logic        exp_id;
    logic        exp_err;
    logic        known;
    logic [31:0] exp_ckey;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (grant != '0) n_grant++;
    if (core_start) n_start++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, {56'd0, grant, busy, resp_valid, resp_id, resp_err, core_rst_n, core_start}, 64'd0);
    check({tag, "_data"}, {resp_ckey, core_key}, 64'd0);
    check({tag, "_klen"}, {56'd0, core_key_length}, 64'd0);
  endtask

  task automatic run_job(input vec_t v, input int idx);
    logic got;
    int g_cyc;
    logic [31:0] exp_ck;
    req         = v.req;
    req_key     = {v.key1, v.key0};
    req_key_len = {v.len1, v.len0};
    resp_ready  = 1'b1;
    n_grant = 0;
    n_start = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (grant != '0) got = 1'b1;
    end
    check($sformatf("grant[%0d]", idx), {62'd0, grant}, {62'd0, v.exp_grant});
    g_cyc = cyc;
    for (int i = 0; i < 3000 && !resp_valid; i++) tick();
    check($sformatf("resp_valid[%0d]", idx), {63'd0, resp_valid}, 64'd1);
    check($sformatf("resp_id[%0d]", idx), {63'd0, resp_id}, {63'd0, v.exp_id});
    check($sformatf("resp_err[%0d]", idx), {63'd0, resp_err}, {63'd0, v.exp_err});
    if (v.exp_err) exp_ck = '0;
    else if (v.known) exp_ck = v.exp_ckey;
    else exp_ck = rc4(v.exp_id ? v.key1 : v.key0, v.exp_id ? v.len1 : v.len0);
    check($sformatf("resp_ckey[%0d]", idx), {32'd0, resp_ckey}, {32'd0, exp_ck});
    if (v.exp_err) begin
      check($sformatf("badlen_latency[%0d]", idx), {63'd0, (cyc - g_cyc) <= 3}, 64'd1);
      check($sformatf("badlen_no_start[%0d]", idx), 64'(n_start), 64'd0);
    end
    check($sformatf("grant_pulses[%0d]", idx), 64'(n_grant), 64'd1);
    tick();
    check($sformatf("valid_drop[%0d]", idx), {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    logic        snap_id;
    logic [31:0] snap_ck;
    logic        snap_err;
    int          bad;
    vec_t        v;

    //           req    key0          len0   key1          len1   grant  id    err   known exp_ckey
    vecs[0] = '{2'b11, 32'h0403_0201, 8'd4, 32'hA5A5_3C3C, 8'd4, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{2'b11, 32'h0403_0201, 8'd4, 32'hA5A5_3C3C, 8'd4, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{2'b11, 32'h0403_0201, 8'd4, 32'hA5A5_3C3C, 8'd4, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{2'b11, 32'h0403_0201, 8'd4, 32'hA5A5_3C3C, 8'd4, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{2'b01, 32'h0403_0201, 8'd4, 32'h0000_0000, 8'd0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
    // "Key" -> keystream EB 9F 77 81
    vecs[5] = '{2'b01, 32'h0079_654B, 8'd3, 32'h0000_0000, 8'd0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h8177_9FEB};
    vecs[6] = '{2'b10, 32'h0000_0000, 8'd0, 32'h1122_3344, 8'd0, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{2'b01, 32'h0403_0201, 8'd5, 32'h0000_0000, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{2'b10, 32'h0000_0000, 8'd0, 32'h0000_00FF, 8'd1, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{2'b11, 32'h0403_0201, 8'd255, 32'h0000_BEEF, 8'd2, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0};

    rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_job(vecs[i], i);
    req = '0;

    // Backpressure: response must hold and no new grant until after handshake.
    req         = 2'b01;
    req_key     = {32'h0, 32'h0403_0201};
    req_key_len = {8'd0, 8'd4};
    resp_ready  = 1'b0;
    for (int i = 0; i < 200 && !resp_valid; i++) tick();
    check("bp_valid", {63'd0, resp_valid}, 64'd1);
    snap_id  = resp_id;
    snap_ck  = resp_ckey;
    snap_err = resp_err;
    check("bp_ckey", {32'd0, snap_ck}, {32'd0, rc4(32'h0403_0201, 8'd4)});
    req = 2'b11;
    n_grant = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!resp_valid || resp_id !== snap_id || resp_ckey !== snap_ck || resp_err !== snap_err) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_no_grant", 64'(n_grant), 64'd0);
    resp_ready = 1'b1;
    tick();
    check("bp_after_hs", {62'd0, resp_valid, grant != '0}, 64'd0);
    tick();
    check("bp_next_grant", {62'd0, grant}, 64'd2);
    for (int i = 0; i < 200 && !resp_valid; i++) tick();
    check("bp_next_id", {63'd0, resp_id}, 64'd1);
    tick();
    req = '0;
    tick();

    // Reset in the middle of RUN.
    core_lat    = 300;
    req         = 2'b01;
    req_key     = {32'h0, 32'h0403_0201};
    req_key_len = {8'd0, 8'd4};
    for (int i = 0; i < 20 && !core_start; i++) tick();
    check("mid_run_start", {63'd0, core_start}, 64'd1);
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    #1;
    check_reset("mid_run_reset");
    tick();
    rst = 1'b0;
    req = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid || busy) bad++;
    end
    check("post_reset_quiet", 64'(bad), 64'd0);
    core_lat = 30;
    v = '{2'b10, 32'h0, 8'd0, 32'hCAFE_F00D, 8'd4, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0};
    run_job(v, 10);
    req = '0;
    tick();

    // Core that never finishes.
    hang_core   = 1'b1;
    req         = 2'b01;
    req_key     = {32'h0, 32'h0403_0201};
    req_key_len = {8'd0, 8'd4};
    resp_ready  = 1'b1;
    n_start = 0;
`ifdef RC4_SCHED_TIMEOUT_EN
    for (int i = 0; i < 300 && !resp_valid; i++) tick();
    check("to_valid", {63'd0, resp_valid}, 64'd1);
    check("to_err", {63'd0, resp_err}, 64'd1);
    check("to_ckey", {32'd0, resp_ckey}, 64'd0);
    check("to_run_cycles", 64'(n_start), 64'(TO));
    req = '0;
    tick();
    check("to_valid_drop", {63'd0, resp_valid}, 64'd0);
`else
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i > 3 && (!busy || resp_valid)) bad++;
    end
    check("hang_busy", 64'(bad), 64'd0);
    check("hang_in_run", {63'd0, core_start}, 64'd1);
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    hang_core = 1'b0;
    tick();
    check("final_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
